// File: rtl/axil_cfg_sequencer_if.sv
// AXI4-Lite bundle between the configuration sequencer (master) and its target (slave).
// The data width is carried for completeness; the sequencer only supports 32 bits.
interface axil_cfg_sequencer_if #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32
);
    logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]                      awprot;
    logic                            awvalid;
    logic                            awready;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata;
    logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb;
    logic                            wvalid;
    logic                            wready;
    logic [1:0]                      bresp;
    logic                            bvalid;
    logic                            bready;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   araddr;
    logic [2:0]                      arprot;
    logic                            arvalid;
    logic                            arready;
    logic [C_M_AXI_DATA_WIDTH-1:0]   rdata;
    logic [1:0]                      rresp;
    logic                            rvalid;
    logic                            rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axil_cfg_sequencer.sv
// Writes C_NUM_REGS configuration words over AXI4-Lite, then reads each one back
// and flags any bad response or readback mismatch in a sticky error bit.
module axil_cfg_sequencer #(
    parameter int                            C_M_AXI_ADDR_WIDTH = 32,
    parameter int                            C_M_AXI_DATA_WIDTH = 32,
    parameter int                            C_NUM_REGS         = 4,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR        = '0
) (
    input  logic                                       ACLK,
    input  logic                                       ARESETN,
    input  logic                                       start,
    input  logic [C_NUM_REGS*C_M_AXI_DATA_WIDTH-1:0]   cfg_data,
    output logic                                       busy,
    output logic                                       done,
    output logic                                       error,
    axil_cfg_sequencer_if.master                       m_axi
);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, FIN} state_t;

    localparam logic [3:0] LAST_IDX = 4'(C_NUM_REGS - 1);

    state_t                                   state;
    state_t                                   state_nxt;
    logic [3:0]                               idx;
    logic                                     aw_done;
    logic                                     w_done;
    logic                                     last;
    logic [C_NUM_REGS*C_M_AXI_DATA_WIDTH-1:0] cfg_q;
    logic [C_M_AXI_DATA_WIDTH-1:0]            cur_reg;
    logic [C_M_AXI_ADDR_WIDTH-1:0]            cur_addr;

    // Byte address of register i; the sum wraps at the address width.
    function automatic logic [C_M_AXI_ADDR_WIDTH-1:0] reg_addr(input logic [3:0] i);
        return C_BASE_ADDR + C_M_AXI_ADDR_WIDTH'({i, 2'b00});
    endfunction

    assign last     = (idx == LAST_IDX);
    assign cur_addr = reg_addr(idx);

    always_comb begin
        cur_reg = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (idx == 4'(i)) cur_reg = cfg_q[i*C_M_AXI_DATA_WIDTH +: C_M_AXI_DATA_WIDTH];
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)                  state_nxt = WR_REQ;
            WR_REQ:  if (aw_done && w_done)      state_nxt = WR_RESP;
            WR_RESP: if (m_axi.bvalid)           state_nxt = last ? RD_REQ : WR_REQ;
            RD_REQ:  if (m_axi.arready)          state_nxt = RD_RESP;
            RD_RESP: if (m_axi.rvalid)           state_nxt = last ? FIN : RD_REQ;
            FIN:                                 state_nxt = IDLE;
            default:                             state_nxt = IDLE;
        endcase
    end

    // Valids are decoded from state and the per-channel completion flags, so an
    // asynchronous reset drops them in the same instant the FSM returns to IDLE.
    always_comb begin
        busy          = (state != IDLE);
        done          = (state == FIN);
        m_axi.awvalid = (state == WR_REQ) && !aw_done;
        m_axi.wvalid  = (state == WR_REQ) && !w_done;
        m_axi.awaddr  = (state == WR_REQ) ? cur_addr : '0;
        m_axi.awprot  = 3'b000;
        m_axi.wdata   = cur_reg;
        m_axi.wstrb   = '1;
        m_axi.bready  = (state == WR_RESP);
        m_axi.arvalid = (state == RD_REQ);
        m_axi.araddr  = (state == RD_REQ) ? cur_addr : '0;
        m_axi.arprot  = 3'b000;
        m_axi.rready  = (state == RD_RESP);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            idx     <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            error   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    idx   <= '0;
                    error <= 1'b0;
                end
                WR_REQ: begin
                    if (m_axi.awvalid && m_axi.awready) aw_done <= 1'b1;
                    if (m_axi.wvalid && m_axi.wready)   w_done  <= 1'b1;
                end
                WR_RESP: if (m_axi.bvalid) begin
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    if (m_axi.bresp != 2'b00) error <= 1'b1;
                    idx <= last ? 4'd0 : idx + 4'd1;
                end
                RD_RESP: if (m_axi.rvalid) begin
                    if (m_axi.rresp != 2'b00 || m_axi.rdata != cur_reg) error <= 1'b1;
                    idx <= last ? 4'd0 : idx + 4'd1;
                end
                default: ;
            endcase
        end
    end

    // Register values are pure data: captured on an accepted start, never reset.
    always_ff @(posedge ACLK) begin
        if (state == IDLE && start) cfg_q <= cfg_data;
    end

endmodule

// File: tb/tb_axil_cfg_sequencer.sv
// Bench for axil_cfg_sequencer: AXI4-Lite slave model with wait-state and fault
// knobs, plus a scoreboard of expected write/read transactions per sequence.
module tb_axil_cfg_sequencer;
    localparam int N = 4;

    logic           ACLK     = 1'b0;
    logic           ARESETN  = 1'b0;
    logic           start    = 1'b0;
    logic [N*32-1:0] cfg_data = '0;
    logic           busy;
    logic           done;
    logic           error;

    int total = 0;
    int bad   = 0;

    axil_cfg_sequencer_if #(.C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32)) m_axi ();

    axil_cfg_sequencer #(
        .C_M_AXI_ADDR_WIDTH(32),
        .C_M_AXI_DATA_WIDTH(32),
        .C_NUM_REGS        (N),
        .C_BASE_ADDR       (32'h0)
    ) dut (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .start   (start),
        .cfg_data(cfg_data),
        .busy    (busy),
        .done    (done),
        .error   (error),
        .m_axi   (m_axi.master)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        bit          rd;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Slave model knobs
    int          aw_delay         = 0;
    logic [31:0] bresp_fault_addr = 32'hFFFF_FFFF;
    logic [31:0] rd_fault_addr    = 32'hFFFF_FFFF;

    int          aw_cnt;
    logic        got_aw;
    logic        got_w;
    logic [31:0] s_awaddr;
    logic [31:0] s_wdata;
    logic [31:0] mem [16];

    assign m_axi.awready = m_axi.awvalid && (aw_cnt >= aw_delay);
    assign m_axi.wready  = m_axi.wvalid;
    assign m_axi.arready = m_axi.arvalid;

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_cnt       <= 0;
            got_aw       <= 1'b0;
            got_w        <= 1'b0;
            m_axi.bvalid <= 1'b0;
            m_axi.bresp  <= 2'b00;
            m_axi.rvalid <= 1'b0;
            m_axi.rresp  <= 2'b00;
            m_axi.rdata  <= '0;
        end else begin
            if (m_axi.awvalid && !m_axi.awready) aw_cnt <= aw_cnt + 1;
            if (m_axi.awvalid && m_axi.awready) begin
                aw_cnt   <= 0;
                got_aw   <= 1'b1;
                s_awaddr <= m_axi.awaddr;
            end
            if (m_axi.wvalid && m_axi.wready) begin
                got_w   <= 1'b1;
                s_wdata <= m_axi.wdata;
            end
            if (got_aw && got_w && !m_axi.bvalid) begin
                mem[s_awaddr[5:2]] <= s_wdata;
                m_axi.bvalid       <= 1'b1;
                m_axi.bresp        <= (s_awaddr == bresp_fault_addr) ? 2'b10 : 2'b00;
                got_aw             <= 1'b0;
                got_w              <= 1'b0;
            end else if (m_axi.bvalid && m_axi.bready) begin
                m_axi.bvalid <= 1'b0;
            end
            if (m_axi.arvalid && m_axi.arready) begin
                m_axi.rvalid <= 1'b1;
                m_axi.rresp  <= 2'b00;
                m_axi.rdata  <= mem[m_axi.araddr[5:2]] ^ ((m_axi.araddr == rd_fault_addr) ? 32'h4 : 32'h0);
            end else if (m_axi.rvalid && m_axi.rready) begin
                m_axi.rvalid <= 1'b0;
            end
        end
    end

    // Monitor: sampled on the falling edge, mid-cycle.
    int          b_cnt   = 0;
    int          ar_cnt  = 0;
    bit          cap_aw  = 0;
    bit          cap_w   = 0;
    bit          aw_wait = 0;
    bit          w_first = 0;
    logic [31:0] m_awaddr;
    logic [31:0] m_wdata;
    logic [31:0] prev_awaddr;

    always @(negedge ACLK) begin
        if (!ARESETN) begin
            cap_aw  = 0;
            cap_w   = 0;
            aw_wait = 0;
        end else begin
            if (m_axi.awvalid) begin
                if (aw_wait) begin
                    total++;
                    if (m_axi.awaddr !== prev_awaddr) begin
                        bad++;
                        $display("FAIL aw_stable: awaddr=%h required=%h", m_axi.awaddr, prev_awaddr);
                    end
                end
                if (!m_axi.wvalid) w_first = 1;
                total++;
                if (m_axi.awprot !== 3'b000) begin
                    bad++;
                    $display("FAIL awprot: got=%b required=000", m_axi.awprot);
                end
                if (m_axi.awready) begin
                    cap_aw   = 1;
                    m_awaddr = m_axi.awaddr;
                    aw_wait  = 0;
                end else begin
                    aw_wait     = 1;
                    prev_awaddr = m_axi.awaddr;
                end
            end
            if (m_axi.wvalid && m_axi.wready) begin
                total++;
                if (m_axi.wstrb !== 4'hF) begin
                    bad++;
                    $display("FAIL wstrb: got=%h required=f", m_axi.wstrb);
                end
                cap_w   = 1;
                m_wdata = m_axi.wdata;
            end
            if (cap_aw && cap_w) begin
                cap_aw = 0;
                cap_w  = 0;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_write: addr=%h data=%h required=no transaction", m_awaddr, m_wdata);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.rd || m_awaddr !== mon_e.addr || m_wdata !== mon_e.data) begin
                        bad++;
                        $display("FAIL write_txn: addr=%h data=%h required rd=%0d addr=%h data=%h",
                                 m_awaddr, m_wdata, mon_e.rd, mon_e.addr, mon_e.data);
                    end
                end
            end
            if (m_axi.bvalid && m_axi.bready) b_cnt++;
            if (m_axi.arvalid && m_axi.arready) begin
                ar_cnt++;
                total++;
                if (m_axi.arprot !== 3'b000) begin
                    bad++;
                    $display("FAIL arprot: got=%b required=000", m_axi.arprot);
                end
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_read: addr=%h required=no transaction", m_axi.araddr);
                end else begin
                    mon_e = sb.pop_front();
                    if (!mon_e.rd || m_axi.araddr !== mon_e.addr) begin
                        bad++;
                        $display("FAIL read_txn: addr=%h required rd=%0d addr=%h", m_axi.araddr, mon_e.rd, mon_e.addr);
                    end
                end
            end
        end
    end

    task automatic push_expect(input logic [N*32-1:0] cfg);
        for (int i = 0; i < N; i++) sb.push_back(exp_t'{1'b0, 32'(4*i), cfg[i*32 +: 32]});
        for (int i = 0; i < N; i++) sb.push_back(exp_t'{1'b1, 32'(4*i), cfg[i*32 +: 32]});
    endtask

    // Runs one sequence; returns the cycle (start cycle = 0) at which done is seen.
    // A start pulse is injected at cycle 'poke' when poke > 0.
    task automatic run_seq(input logic [N*32-1:0] cfg, input int poke, output int cyc);
        push_expect(cfg);
        @(negedge ACLK);
        cfg_data = cfg;
        start    = 1'b1;
        @(negedge ACLK);
        start = 1'b0;
        cyc   = 1;
        while (!done && cyc < 400) begin
            @(negedge ACLK);
            cyc++;
            start = (cyc == poke);
        end
        start = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL done_timeout: cycles=%0d required=done pulse", cyc);
        end
    endtask

    task automatic test_reset();
        ARESETN = 1'b0;
        start   = 1'b1;
        repeat (3) @(negedge ACLK);
        total++;
        if ({busy, done, error} !== 3'b000) begin
            bad++;
            $display("FAIL reset_status: busy/done/error=%b required=000", {busy, done, error});
        end
        total++;
        if ({m_axi.awvalid, m_axi.wvalid, m_axi.bready, m_axi.arvalid, m_axi.rready} !== 5'b0) begin
            bad++;
            $display("FAIL reset_handshake: aw/w/b/ar/r=%b required=00000",
                     {m_axi.awvalid, m_axi.wvalid, m_axi.bready, m_axi.arvalid, m_axi.rready});
        end
        total++;
        if (m_axi.awaddr !== 32'h0 || m_axi.araddr !== 32'h0) begin
            bad++;
            $display("FAIL reset_addr: awaddr=%h araddr=%h required=0", m_axi.awaddr, m_axi.araddr);
        end
        start   = 1'b0;
        ARESETN = 1'b1;
        repeat (3) @(negedge ACLK);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: busy=%b required=0", busy);
        end
    endtask

    task automatic test_zero_wait();
        logic [N*32-1:0] cfg = {32'd4, 32'd3, 32'd2, 32'd1};
        int cyc;
        int b0 = b_cnt;
        run_seq(cfg, 0, cyc);
        total++;
        if (cyc !== 21) begin
            bad++;
            $display("FAIL zw_latency: done_cycle=%0d required=21", cyc);
        end
        total++;
        if (busy !== 1'b1 || error !== 1'b0) begin
            bad++;
            $display("FAIL zw_fin: busy=%b error=%b required busy=1 error=0", busy, error);
        end
        @(negedge ACLK);
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL zw_done_pulse: done=%b busy=%b required=0 0", done, busy);
        end
        total++;
        if (sb.size() != 0 || b_cnt - b0 != N) begin
            bad++;
            $display("FAIL zw_count: left=%0d b=%0d required left=0 b=%0d", sb.size(), b_cnt - b0, N);
        end
        for (int i = 0; i < N; i++) begin
            total++;
            if (mem[i] !== cfg[i*32 +: 32]) begin
                bad++;
                $display("FAIL zw_mem%0d: got=%h required=%h", i, mem[i], cfg[i*32 +: 32]);
            end
        end
    endtask

    task automatic test_bresp_err();
        int cyc;
        int b0 = b_cnt;
        bresp_fault_addr = 32'h4;
        run_seq({32'h44, 32'h33, 32'h22, 32'h11}, 0, cyc);
        total++;
        if (cyc !== 21 || error !== 1'b1) begin
            bad++;
            $display("FAIL bresp_fin: done_cycle=%0d error=%b required 21 1", cyc, error);
        end
        @(negedge ACLK);
        total++;
        if (error !== 1'b1 || sb.size() != 0 || b_cnt - b0 != N) begin
            bad++;
            $display("FAIL bresp_after: error=%b left=%0d b=%0d required 1 0 %0d", error, sb.size(), b_cnt - b0, N);
        end
        bresp_fault_addr = 32'hFFFF_FFFF;
    endtask

    task automatic test_aw_delay();
        int cyc;
        int b0 = b_cnt;
        aw_delay = 3;
        w_first  = 0;
        run_seq({32'hDEAD_0004, 32'hBEEF_0003, 32'hCAFE_0002, 32'hF00D_0001}, 0, cyc);
        aw_delay = 0;
        total++;
        if (cyc !== 33 || error !== 1'b0) begin
            bad++;
            $display("FAIL awd_fin: done_cycle=%0d error=%b required 33 0", cyc, error);
        end
        total++;
        if (w_first !== 1'b1) begin
            bad++;
            $display("FAIL awd_w_first: seen=%b required=1", w_first);
        end
        @(negedge ACLK);
        total++;
        if (sb.size() != 0 || b_cnt - b0 != N) begin
            bad++;
            $display("FAIL awd_count: left=%0d b=%0d required left=0 b=%0d", sb.size(), b_cnt - b0, N);
        end
    endtask

    task automatic test_rd_corrupt();
        int cyc;
        rd_fault_addr = 32'h8;
        run_seq({32'd4, 32'd3, 32'd2, 32'd1}, 5, cyc);
        total++;
        if (cyc !== 21 || error !== 1'b1) begin
            bad++;
            $display("FAIL rdc_fin: done_cycle=%0d error=%b required 21 1", cyc, error);
        end
        repeat (10) @(negedge ACLK);
        total++;
        if (busy !== 1'b0 || error !== 1'b1 || sb.size() != 0) begin
            bad++;
            $display("FAIL rdc_after: busy=%b error=%b left=%0d required 0 1 0", busy, error, sb.size());
        end
        rd_fault_addr = 32'hFFFF_FFFF;
    endtask

    task automatic test_reset_mid();
        logic [N*32-1:0] cfg = {32'hA4, 32'hB3, 32'hC2, 32'hD1};
        int a0 = ar_cnt;
        int n  = 0;
        int cyc;
        push_expect(cfg);
        @(negedge ACLK);
        cfg_data = cfg;
        start    = 1'b1;
        @(negedge ACLK);
        start = 1'b0;
        while (!(m_axi.rready && ar_cnt == a0 + 2) && n < 100) begin
            @(negedge ACLK);
            n++;
        end
        total++;
        if (n >= 100) begin
            bad++;
            $display("FAIL rst_mid_reach: cycles=%0d required=RD_RESP of reg 1", n);
        end
        ARESETN = 1'b0;
        #1;
        total++;
        if ({m_axi.awvalid, m_axi.wvalid, m_axi.bready, m_axi.arvalid, m_axi.rready} !== 5'b0) begin
            bad++;
            $display("FAIL rst_mid_valids: aw/w/b/ar/r=%b required=00000",
                     {m_axi.awvalid, m_axi.wvalid, m_axi.bready, m_axi.arvalid, m_axi.rready});
        end
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_busy: busy=%b done=%b required=0 0", busy, done);
        end
        sb.delete();
        repeat (3) @(negedge ACLK);
        ARESETN = 1'b1;
        repeat (10) @(negedge ACLK);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_quiet: busy=%b required=0", busy);
        end
        run_seq({32'h0000_1004, 32'h0000_1003, 32'h0000_1002, 32'h0000_1001}, 0, cyc);
        total++;
        if (cyc !== 21 || error !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_rerun: done_cycle=%0d error=%b required 21 0", cyc, error);
        end
        @(negedge ACLK);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL rst_mid_left: left=%0d required=0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_bresp_err();
        test_aw_delay();
        test_rd_corrupt();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time=%0t required=bench completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
